// File: rtl/instr_prefetch.sv
// Instruction prefetch stage: sequential word fetch, small FIFO, redirect flush.
// Define PREFETCH_STATS_EN to add saturating stat_fetched / stat_dropped counters.
module instr_prefetch #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic clk,
    input  logic r,
    output logic mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic ins_valid,
    output logic [DATA_W-1:0] ins_data,
    output logic [ADDR_W-1:0] ins_pc,
    input  logic ins_ready,
`ifdef PREFETCH_STATS_EN
    output logic [15:0] stat_fetched,
    output logic [15:0] stat_dropped,
`endif
    output logic [$clog2(DEPTH):0] fill_level
);

    localparam int PW = $clog2(DEPTH);
    localparam int FW = PW + 1;
    localparam logic [FW-1:0] FULL = FW'(DEPTH);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t state;
    logic [ADDR_W-1:0] pc;
    logic discard;

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [FW-1:0] count;

    logic acked;
    logic push;
    logic pop;

    assign acked = (state == WAIT) && mem_ack;
    assign push = acked && !discard && !redirect;
    assign pop = ins_valid && ins_ready && !redirect;

    assign ins_valid = (count != '0);
    assign ins_data = ins_valid ? data_q[rptr] : '0;
    assign ins_pc = ins_valid ? addr_q[rptr] : '0;
    assign fill_level = count;

    // Requests only issue from IDLE, where nothing is pending, so a free
    // slot is always reserved for the word in flight.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state <= IDLE;
            pc <= RESET_PC;
            mem_req <= 1'b0;
            mem_addr <= RESET_PC;
            discard <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (redirect) begin
                        pc <= redirect_pc;
                    end else if (count < FULL) begin
                        state <= WAIT;
                        mem_req <= 1'b1;
                        mem_addr <= pc;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        state <= IDLE;
                        mem_req <= 1'b0;
                        discard <= 1'b0;
                    end else if (redirect) begin
                        discard <= 1'b1;
                    end
                    if (redirect) begin
                        pc <= redirect_pc;
                    end else if (push) begin
                        pc <= pc + ADDR_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else if (redirect) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10: count <= count + FW'(1);
                2'b01: count <= count - FW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wptr] <= mem_rdata;
            addr_q[wptr] <= mem_addr;
        end
    end

`ifdef PREFETCH_STATS_EN
    logic [FW:0] flushed;
    logic [FW:0] dropped_n;
    logic [16:0] fetched_sum;
    logic [16:0] dropped_sum;

    // A head popped in the redirect cycle was taken by the CPU, not dropped.
    always_comb begin
        flushed = '0;
        if (redirect) begin
            flushed = {1'b0, count} - {{FW{1'b0}}, ins_valid && ins_ready};
        end
        dropped_n = flushed + {{FW{1'b0}}, acked && (discard || redirect)};
    end

    assign fetched_sum = {1'b0, stat_fetched} + {16'd0, push};
    assign dropped_sum = {1'b0, stat_dropped} + 17'(dropped_n);

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            stat_fetched <= '0;
            stat_dropped <= '0;
        end else begin
            stat_fetched <= fetched_sum[16] ? 16'hFFFF : fetched_sum[15:0];
            stat_dropped <= dropped_sum[16] ? 16'hFFFF : dropped_sum[15:0];
        end
    end
`endif

endmodule
